lut_sched: RTL and testbench
============================

# lut_sched

Programmable key/value lookup table shared between NR_REQ requesters. Holds NR_KEY register entries (key, data, valid), written through a configuration port. Requesters are served one at a time by a round-robin arbiter, and each served lookup returns a registered response over a valid/ready handshake. It sits between decode/CSR-style producers and the key-match mux datapath, and is the only owner of the table contents.

## Interface
Parameters:
- NR_KEY, 4, number of table entries
- KEY_LEN, 4, key width
- DATA_LEN, 8, data width
- NR_REQ, 2, number of requesters (≥1)
- HAS_DEFAULT, 1, on a miss: 1 returns default_data, 0 returns zero

Ports:
- clk  in  1  clock; the block has one clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  writes entry cfg_idx and sets its valid bit
- cfg_idx  in  $clog2(NR_KEY)  entry index; values ≥ NR_KEY are ignored
- cfg_key  in  KEY_LEN  key to write
- cfg_data  in  DATA_LEN  data to write
- cfg_clr  in  1  clears all valid bits
- default_data  in  DATA_LEN  miss value when HAS_DEFAULT=1
- req_valid  in  NR_REQ  per-requester request
- req_key  in  NR_REQ*KEY_LEN  packed keys; requester i uses bits [KEY_LEN*(i+1)-1 : KEY_LEN*i]
- req_ready  out  NR_REQ  one-hot or zero grant
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_id  out  max(1,$clog2(NR_REQ))  index of the served requester
- rsp_data  out  DATA_LEN  lookup result
- rsp_hit  out  1  at least one valid entry matched

## Operation
- Two-state FSM with states IDLE and BUSY.
- IDLE:
  - req_ready is asserted combinationally to the first requester with req_valid set, searching from ptr upward modulo NR_REQ.
  - A request is accepted when req_valid[i] and req_ready[i] are both high.
  - On accept, the block registers rsp_id=i, rsp_data, rsp_hit and rsp_valid=1, sets ptr=(i+1) mod NR_REQ, and moves to BUSY.
- BUSY:
  - req_ready is all zero.
  - Outputs are held stable until rsp_ready is high.
  - On rsp_valid & rsp_ready: rsp_valid=0 and the FSM returns to IDLE. rsp_data, rsp_hit and rsp_id keep their last values.
- Match rule:
  - Entry n matches when valid[n] is set and key[n]==key.
  - Data is the bitwise OR of the data of all matching entries, so duplicate keys OR together.
  - hit = OR of all match bits.
  - On a miss: data = HAS_DEFAULT ? default_data : 0, and hit=0.
- Configuration:
  - Allowed in any state.
  - cfg_clr takes priority over cfg_we in the same cycle: the cfg_we key/data are written, but all valid bits end up cleared.
  - An out-of-range cfg_idx produces no state change.
- Requesters hold req_valid and their key stable until granted. A request dropped before its grant is simply not served.

## Timing
- Reset values:
  - state=IDLE, ptr=0
  - all valid bits 0, all table keys and data 0
  - rsp_valid=0, rsp_data=0, rsp_hit=0, rsp_id=0
- Lookup latency: accept in cycle T gives rsp_valid=1 in T+1.
- Maximum throughput is one lookup per 2 cycles. No accept happens in the same cycle as a response fire.
- Config write in the same cycle as an accept: the lookup uses the pre-write table. The write is visible to accepts from the next cycle on.
- A config write during BUSY does not alter a response that is already registered.
- rst mid-operation discards the pending response. rsp_valid=0 in the cycle after rst is sampled.
- With a single active requester and rsp_ready tied high, that requester is granted every other cycle.

## Structure
- Package lut_sched_pkg contains:
  - the FSM state enum (IDLE, BUSY)
  - a localparam helper for index widths (max(1, clog2))
- Sub-module lut_match (combinational):
  - inputs: table keys, data, valid bits, lookup key, default_data
  - outputs: match data and hit
  - parameterized by NR_KEY, KEY_LEN, DATA_LEN, HAS_DEFAULT
- Top level contains the table registers, the round-robin arbiter, the FSM and the response registers.

## Test plan
- Reset, then write entry0=(key 3, data 0xA5). Requester 0 looks up key 3 → rsp_valid at T+1, rsp_data=0xA5, rsp_hit=1, rsp_id=0.
- Miss with HAS_DEFAULT=1 and default_data=0x7E: key 9 → rsp_data=0x7E, rsp_hit=0. Same case with HAS_DEFAULT=0 → rsp_data=0x00.
- Requesters 0 and 1 both valid continuously, rsp_ready=1 → grants alternate 0,1,0,1. req_ready is never asserted in BUSY.
- Hold rsp_ready=0 for 5 cycles → rsp_* stable and req_ready=0 throughout. Raising rsp_ready returns to IDLE with the next grant one cycle later.
- Duplicate keys: entry1=(key 5, data 0x0F) and entry2=(key 5, data 0xF0) → data 0xFF. Then cfg_clr → key 5 misses.
- Write entry0 data 0x11 in the same cycle as an accept for key 3 → response returns the old 0xA5; the next lookup returns 0x11. Assert rst while in BUSY → rsp_valid=0 and the table is empty.

Source files
------------

// File: rtl/lut_sched_pkg.sv
// lut_sched_pkg: shared FSM state type and index-width helper for the lookup scheduler
package lut_sched_pkg;
   typedef enum logic {IDLE, BUSY} state_t;
   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction
endpackage

// File: rtl/lut_match.sv
// lut_match: combinational key match over the table, OR-combining data of all hits
module lut_match #(
   parameter int NR_KEY      = 4,
   parameter int KEY_LEN     = 4,
   parameter int DATA_LEN    = 8,
   parameter int HAS_DEFAULT = 1
) (
   input  logic [NR_KEY*KEY_LEN-1:0]  keys,
   input  logic [NR_KEY*DATA_LEN-1:0] data,
   input  logic [NR_KEY-1:0]          valid,
   input  logic [KEY_LEN-1:0]         key,
   input  logic [DATA_LEN-1:0]        default_data,
   output logic [DATA_LEN-1:0]        match_data,
   output logic                       hit
);
   logic [DATA_LEN-1:0] acc;
   always_comb begin
      acc = '0;
      hit = 1'b0;
      for (int n = 0; n < NR_KEY; n++)
         if (valid[n] && keys[n*KEY_LEN +: KEY_LEN] == key) begin
            acc = acc | data[n*DATA_LEN +: DATA_LEN];
            hit = 1'b1;
         end
   end
   assign match_data = hit ? acc : ((HAS_DEFAULT != 0) ? default_data : '0);
endmodule

// File: rtl/lut_sched.sv
// lut_sched: round-robin shared key/value lookup table with registered valid/ready response
module lut_sched import lut_sched_pkg::*; #(
   parameter  int NR_KEY      = 4,
   parameter  int KEY_LEN     = 4,
   parameter  int DATA_LEN    = 8,
   parameter  int NR_REQ      = 2,
   parameter  int HAS_DEFAULT = 1,
   localparam int KW          = idx_w(NR_KEY),
   localparam int IW          = idx_w(NR_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      cfg_we,
   input  logic [KW-1:0]             cfg_idx,
   input  logic [KEY_LEN-1:0]        cfg_key,
   input  logic [DATA_LEN-1:0]       cfg_data,
   input  logic                      cfg_clr,
   input  logic [DATA_LEN-1:0]       default_data,
   input  logic [NR_REQ-1:0]         req_valid,
   input  logic [NR_REQ*KEY_LEN-1:0] req_key,
   output logic [NR_REQ-1:0]         req_ready,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [IW-1:0]             rsp_id,
   output logic [DATA_LEN-1:0]       rsp_data,
   output logic                      rsp_hit
);
   state_t                     state;
   logic [IW-1:0]              ptr, gnt_id, gnt_nxt;
   logic [NR_REQ-1:0]          gnt;
   logic                       found, in_rng, m_hit;
   logic [NR_KEY*KEY_LEN-1:0]  tab_key;
   logic [NR_KEY*DATA_LEN-1:0] tab_data;
   logic [NR_KEY-1:0]          tab_vld;
   logic [KEY_LEN-1:0]         sel_key;
   logic [DATA_LEN-1:0]        m_data;
   int                         j;

   // first requesting index at or after ptr, wrapping
   always_comb begin
      gnt = '0;
      gnt_id = '0;
      gnt_nxt = '0;
      found = 1'b0;
      j = 0;
      for (int k = 0; k < NR_REQ; k++) begin
         j = (int'(ptr) + k) % NR_REQ;
         if (!found && req_valid[j]) begin
            gnt[j] = 1'b1;
            gnt_id = IW'(j);
            gnt_nxt = IW'((j + 1) % NR_REQ);
            found = 1'b1;
         end
      end
   end

   assign req_ready = (state == IDLE) ? gnt : '0;
   assign sel_key   = req_key[int'(gnt_id)*KEY_LEN +: KEY_LEN];
   assign in_rng    = int'(cfg_idx) < NR_KEY;

   lut_match #(
      .NR_KEY(NR_KEY), .KEY_LEN(KEY_LEN), .DATA_LEN(DATA_LEN), .HAS_DEFAULT(HAS_DEFAULT)
   ) u_match (
      .keys(tab_key), .data(tab_data), .valid(tab_vld), .key(sel_key),
      .default_data(default_data), .match_data(m_data), .hit(m_hit)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         ptr <= '0;
         tab_key <= '0;
         tab_data <= '0;
         tab_vld <= '0;
         rsp_valid <= 1'b0;
         rsp_data <= '0;
         rsp_hit <= 1'b0;
         rsp_id <= '0;
      end else begin
         if (cfg_we && in_rng) begin
            tab_key[int'(cfg_idx)*KEY_LEN +: KEY_LEN] <= cfg_key;
            tab_data[int'(cfg_idx)*DATA_LEN +: DATA_LEN] <= cfg_data;
            tab_vld[int'(cfg_idx)] <= 1'b1;
         end
         if (cfg_clr)
            tab_vld <= '0;
         if (state == IDLE && found) begin
            rsp_id <= gnt_id;
            rsp_data <= m_data;
            rsp_hit <= m_hit;
            rsp_valid <= 1'b1;
            ptr <= gnt_nxt;
            state <= BUSY;
         end else if (state == BUSY && rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= IDLE;
         end
      end
   end
endmodule

// File: tb/tb_lut_sched.sv
// tb_lut_sched: directed checks of lookup, arbitration, backpressure, config and reset
module tb_lut_sched;
   logic       clk = 1'b0;
   logic       rst, cfg_we, cfg_clr, rsp_ready;
   logic [1:0] cfg_idx, req_valid, req_ready, req_ready0;
   logic [3:0] cfg_key;
   logic [7:0] cfg_data, default_data, rsp_data, rsp_data0;
   logic [7:0] req_key;
   logic       rsp_valid, rsp_hit, rsp_valid0, rsp_hit0;
   logic [0:0] rsp_id, rsp_id0;
   int         n_cmp = 0, n_err = 0;

   always #5 clk = ~clk;

   lut_sched #(.HAS_DEFAULT(1)) u_dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
      .cfg_data(cfg_data), .cfg_clr(cfg_clr), .default_data(default_data),
      .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_data(rsp_data), .rsp_hit(rsp_hit)
   );

   lut_sched #(.HAS_DEFAULT(0)) u_dut0 (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_key(cfg_key),
      .cfg_data(cfg_data), .cfg_clr(cfg_clr), .default_data(default_data),
      .req_valid(req_valid), .req_key(req_key), .req_ready(req_ready0),
      .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_id(rsp_id0),
      .rsp_data(rsp_data0), .rsp_hit(rsp_hit0)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] idx, input logic [3:0] k, input logic [7:0] d);
      cfg_we = 1'b1;
      cfg_idx = idx;
      cfg_key = k;
      cfg_data = d;
      tick();
      cfg_we = 1'b0;
   endtask

   // raises a request, waits (bounded) for its grant, then drops it after the accept edge
   task automatic lookup(input int r, input logic [3:0] k);
      int w;
      w = 0;
      req_key[r*4 +: 4] = k;
      req_valid[r] = 1'b1;
      #1;
      while (req_ready[r] !== 1'b1 && w < 10) begin
         tick();
         w++;
      end
      chk("grant", 32'(req_ready[r]), 32'd1);
      tick();
      req_valid[r] = 1'b0;
   endtask

   initial begin
      rst = 1'b1; cfg_we = 1'b0; cfg_clr = 1'b0; cfg_idx = '0; cfg_key = '0; cfg_data = '0;
      default_data = 8'h7E; req_valid = '0; req_key = '0; rsp_ready = 1'b1;
      tick();
      tick();
      chk("rst_valid", 32'(rsp_valid), 32'd0);
      chk("rst_data", 32'(rsp_data), 32'd0);
      chk("rst_hit", 32'(rsp_hit), 32'd0);
      chk("rst_id", 32'(rsp_id), 32'd0);
      rst = 1'b0;
      cfg_write(2'd0, 4'd3, 8'hA5);
      lookup(0, 4'd3);
      chk("hit_valid", 32'(rsp_valid), 32'd1);
      chk("hit_data", 32'(rsp_data), 32'hA5);
      chk("hit_hit", 32'(rsp_hit), 32'd1);
      chk("hit_id", 32'(rsp_id), 32'd0);
      chk("busy_ready", 32'(req_ready), 32'd0);
      tick();
      lookup(0, 4'd9);
      chk("miss_data_def", 32'(rsp_data), 32'h7E);
      chk("miss_hit_def", 32'(rsp_hit), 32'd0);
      chk("miss_data_zero", 32'(rsp_data0), 32'h00);
      chk("miss_hit_zero", 32'(rsp_hit0), 32'd0);
      tick();
      // ptr is 1 after two requester-0 lookups, so grants go 1,0,1,0
      req_key = {4'd3, 4'd3};
      req_valid = 2'b11;
      #1;
      for (int i = 0; i < 4; i++) begin
         chk("rr_grant", 32'(req_ready), (i % 2 == 0) ? 32'd2 : 32'd1);
         tick();
         chk("rr_id", 32'(rsp_id), (i % 2 == 0) ? 32'd1 : 32'd0);
         chk("rr_busy_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b0;
      tick();
      for (int i = 0; i < 5; i++) begin
         chk("hold_valid", 32'(rsp_valid), 32'd1);
         chk("hold_id", 32'(rsp_id), 32'd1);
         chk("hold_data", 32'(rsp_data), 32'hA5);
         chk("hold_ready", 32'(req_ready), 32'd0);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("rel_valid", 32'(rsp_valid), 32'd0);
      chk("rel_id_kept", 32'(rsp_id), 32'd1);
      chk("rel_grant", 32'(req_ready), 32'd1);
      tick();
      chk("rel_next_id", 32'(rsp_id), 32'd0);
      chk("rel_next_valid", 32'(rsp_valid), 32'd1);
      req_valid = '0;
      tick();
      cfg_write(2'd1, 4'd5, 8'h0F);
      cfg_write(2'd2, 4'd5, 8'hF0);
      lookup(0, 4'd5);
      chk("dup_data", 32'(rsp_data), 32'hFF);
      chk("dup_hit", 32'(rsp_hit), 32'd1);
      tick();
      cfg_clr = 1'b1;
      tick();
      cfg_clr = 1'b0;
      lookup(0, 4'd5);
      chk("clr_data", 32'(rsp_data), 32'h7E);
      chk("clr_hit", 32'(rsp_hit), 32'd0);
      chk("clr_data_zero", 32'(rsp_data0), 32'h00);
      tick();
      cfg_write(2'd0, 4'd3, 8'hA5);
      req_key[3:0] = 4'd3;
      req_valid = 2'b01;
      cfg_we = 1'b1; cfg_idx = 2'd0; cfg_key = 4'd3; cfg_data = 8'h11;
      #1;
      chk("wr_acc_grant", 32'(req_ready), 32'd1);
      tick();
      cfg_we = 1'b0;
      req_valid = '0;
      chk("wr_acc_old", 32'(rsp_data), 32'hA5);
      tick();
      lookup(0, 4'd3);
      chk("wr_acc_new", 32'(rsp_data), 32'h11);
      chk("wr_acc_new_hit", 32'(rsp_hit), 32'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
      chk("mid_rst_data", 32'(rsp_data), 32'd0);
      lookup(0, 4'd3);
      chk("empty_data", 32'(rsp_data), 32'h7E);
      chk("empty_hit", 32'(rsp_hit), 32'd0);
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
